// File: rtl/led_pkg.sv
// led_pkg: shared LED width, serial driver states and bit-order helpers
package led_pkg;
  localparam int LED_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;
  function automatic logic [LED_WIDTH-1:0] shift_out(input logic [LED_WIDTH-1:0] v, input bit msb_first);
    return msb_first ? {v[LED_WIDTH-2:0], 1'b0} : {1'b0, v[LED_WIDTH-1:1]};
  endfunction
  function automatic logic head(input logic [LED_WIDTH-1:0] v, input bit msb_first);
    return msb_first ? v[LED_WIDTH-1] : v[0];
  endfunction
endpackage

// File: rtl/led_serial_driver_if.sv
// led_serial_driver_if: LED vector input and serial shift/latch outputs
interface led_serial_driver_if;
  import led_pkg::*;
  logic [LED_WIDTH-1:0] led_in;
  logic sclk;
  logic sdata;
  logic latch;
  logic busy;
  logic frame_done;
  modport master(output led_in, input sclk, sdata, latch, busy, frame_done);
  modport slave(input led_in, output sclk, sdata, latch, busy, frame_done);
endinterface

// File: rtl/led_clk_div.sv
// led_clk_div: one-cycle tick every CLK_DIV enabled cycles, held cleared while disabled
module led_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = en_i && cnt_q == 8'(CLK_DIV - 1);
    cnt_d = (!en_i || tick_o) ? 8'd0 : cnt_q + 8'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_serial_driver.sv
// led_serial_driver: shifts changed LED vectors out to an external shift/latch register
module led_serial_driver
  import led_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1
) (
  input logic clk,
  input logic rst_n,
  led_serial_driver_if.slave bus
);
  state_e state_q, state_d;
  logic [LED_WIDTH-1:0] shift_q, shift_d, shadow_q, shadow_d;
  logic [4:0] cnt_q, cnt_d;
  logic init_q, init_d, sclk_q, sclk_d, sdata_q, sdata_d;
  logic latch_q, latch_d, busy_q, busy_d, done_q, done_d;
  logic tick;
  led_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(state_q != IDLE),
    .tick_o(tick)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    shadow_d = shadow_q;
    cnt_d = cnt_q;
    init_d = init_q;
    sclk_d = sclk_q;
    sdata_d = sdata_q;
    latch_d = latch_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.led_in != shadow_q || init_q) begin
        state_d = SHIFT;
        shift_d = bus.led_in;
        shadow_d = bus.led_in;
        init_d = 1'b0;
        busy_d = 1'b1;
        sdata_d = head(bus.led_in, MSB_FIRST);
        sclk_d = 1'b0;
        cnt_d = '0;
      end
      SHIFT: if (tick) begin
        sclk_d = !sclk_q;
        if (sclk_q) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(LED_WIDTH - 1)) begin
            state_d = LATCH;
            latch_d = 1'b1;
          end else begin
            shift_d = shift_out(shift_q, MSB_FIRST);
            sdata_d = head(shift_d, MSB_FIRST);
          end
        end
      end
      LATCH: if (tick) begin
        state_d = IDLE;
        latch_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b1;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      shadow_q <= '0;
      cnt_q <= '0;
      init_q <= 1'b1;
      sclk_q <= 1'b0;
      sdata_q <= 1'b0;
      latch_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      shadow_q <= shadow_d;
      cnt_q <= cnt_d;
      init_q <= init_d;
      sclk_q <= sclk_d;
      sdata_q <= sdata_d;
      latch_q <= latch_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.sclk = sclk_q;
  assign bus.sdata = sdata_q;
  assign bus.latch = latch_q;
  assign bus.busy = busy_q;
  assign bus.frame_done = done_q;
endmodule
